// File: rtl/pipe_arb_pkg.sv
// Shared types and constants for the two-source pipeline bus arbiter.
package pipe_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic SRC_LSB = 1'b0;
    localparam logic SRC_MSB = 1'b1;

    localparam int unsigned DEF_NBITS = 7;

endpackage

// File: rtl/mux.sv
// Parameterised 2:1 selector; rst forces the output to zero.
module mux #(
    parameter int unsigned nbits = 7
) (
    input  logic             rst,
    input  logic             dec,
    input  logic [nbits-1:0] in0,
    input  logic [nbits-1:0] in1,
    output logic [nbits-1:0] out_c
);

    always_comb begin
        out_c = '0;
        if (!rst) begin
            out_c = dec ? in1 : in0;
        end
    end

endmodule

// File: rtl/pipe_bus_arbiter.sv
// Round-robin burst arbiter sharing the pipeline bus between an LSB and an MSB
// source, with a registered valid/ready output stage.
module pipe_bus_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int unsigned NBITS     = DEF_NBITS,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_lsb,
    input  logic [NBITS-1:0] data_lsb,
    input  logic             last_lsb,
    output logic             ack_lsb,
    input  logic             req_msb,
    input  logic [NBITS-1:0] data_msb,
    input  logic             last_msb,
    output logic             ack_msb,
    output logic [NBITS-1:0] out_data,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             grant_lsb,
    output logic             grant_msb,
    output logic             busy
);

    localparam int unsigned     CNTW     = 8;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_BURST - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_win;
    logic              r_sel;
    logic              r_grant_lsb;
    logic              r_grant_msb;
    logic [CNTW-1:0]   r_cnt;
    logic [NBITS-1:0]  r_out_data;
    logic              r_out_sel;
    logic              r_out_valid;

    logic [NBITS-1:0]  w_sel_data;
    logic              w_free;
    logic              w_ack_lsb;
    logic              w_ack_msb;
    logic              w_ack;
    logic              w_last;
    logic              w_end;
    logic              w_start;
    logic              w_win;

    mux #(
        .nbits (NBITS)
    ) u_mux (
        .rst   (1'b0),
        .dec   (r_sel),
        .in0   (data_lsb),
        .in1   (data_msb),
        .out_c (w_sel_data)
    );

    // Accept only when the output register is empty or draining this cycle.
    assign w_free    = !r_out_valid || out_ready;
    assign w_ack_lsb = r_grant_lsb && req_lsb && w_free;
    assign w_ack_msb = r_grant_msb && req_msb && w_free;
    assign w_ack     = w_ack_lsb || w_ack_msb;
    assign w_last    = (r_sel == SRC_MSB) ? last_msb : last_lsb;
    assign w_end     = w_ack && (w_last || (r_cnt == CNT_LAST));

    // Next state and arbitration decision.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_win        = r_sel;
        case (r_state)
            IDLE: begin
                if (req_lsb || req_msb) begin
                    w_next_state = BURST;
                    w_start      = 1'b1;
                    w_win        = (req_lsb && req_msb) ? !r_last_win : req_msb;
                end
            end
            BURST: begin
                if (w_end) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant, pointer, beat counter and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_win  <= SRC_MSB;
            r_sel       <= SRC_LSB;
            r_grant_lsb <= 1'b0;
            r_grant_msb <= 1'b0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_sel   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_start) begin
                r_sel       <= w_win;
                r_cnt       <= '0;
                r_grant_lsb <= (w_win == SRC_LSB);
                r_grant_msb <= (w_win == SRC_MSB);
            end
            if (w_ack) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
            if (w_end) begin
                r_last_win  <= r_sel;
                r_grant_lsb <= 1'b0;
                r_grant_msb <= 1'b0;
            end
            if (w_ack) begin
                r_out_data  <= w_sel_data;
                r_out_sel   <= r_sel;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign ack_lsb   = w_ack_lsb;
    assign ack_msb   = w_ack_msb;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
    assign grant_lsb = r_grant_lsb;
    assign grant_msb = r_grant_msb;
    assign busy      = (r_state == BURST);

endmodule

// File: tb/tb_pipe_bus_arbiter.sv
// Directed self-checking bench for pipe_bus_arbiter (instance built with MAX_BURST = 4).
module tb_pipe_bus_arbiter;

    localparam int unsigned NBITS = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_lsb, last_lsb, ack_lsb;
    logic             req_msb, last_msb, ack_msb;
    logic [NBITS-1:0] data_lsb, data_msb, out_data;
    logic             out_sel, out_valid, out_ready;
    logic             grant_lsb, grant_msb, busy;

    int errors = 0;
    int checks = 0;

    logic             ev;
    logic [NBITS-1:0] ed;
    logic             es;

    pipe_bus_arbiter #(
        .NBITS     (NBITS),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_lsb   (req_lsb),
        .data_lsb  (data_lsb),
        .last_lsb  (last_lsb),
        .ack_lsb   (ack_lsb),
        .req_msb   (req_msb),
        .data_msb  (data_msb),
        .last_msb  (last_msb),
        .ack_msb   (ack_msb),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_lsb (grant_lsb),
        .grant_msb (grant_msb),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_lsb   = 1'b0;
        req_msb   = 1'b0;
        last_lsb  = 1'b0;
        last_msb  = 1'b0;
        data_lsb  = '0;
        data_msb  = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        ev  = 1'b0;
        ed  = '0;
        es  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_data, out_sel, out_valid, grant_lsb, grant_msb, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 000",
                     {out_data, out_sel, out_valid, grant_lsb, grant_msb, busy});
        end
        req_lsb = 1'b1;
        req_msb = 1'b1;
        #1;
        checks++;
        if ({ack_lsb, ack_msb} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle_ack got %b exp 00", {ack_lsb, ack_msb});
        end
        req_lsb = 1'b0;
        req_msb = 1'b0;
    endtask

    task automatic test_single_lsb();
        bit gl [6];
        bit al [6];
        int cl;
        gl = '{0, 1, 1, 1, 0, 0};
        al = '{0, 1, 1, 1, 0, 0};
        cl = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req_lsb  = (cl < 3);
            data_lsb = NBITS'(17 * (cl + 1));
            last_lsb = (cl == 2);
            #1;
            checks++;
            if ({grant_lsb, grant_msb, busy} !== {gl[c], 1'b0, gl[c]}) begin
                errors++;
                $display("FAIL single_status c=%0d got %b exp %b", c,
                         {grant_lsb, grant_msb, busy}, {gl[c], 1'b0, gl[c]});
            end
            checks++;
            if ({ack_lsb, ack_msb} !== {al[c], 1'b0}) begin
                errors++;
                $display("FAIL single_ack c=%0d got %b exp %b", c, {ack_lsb, ack_msb}, {al[c], 1'b0});
            end
            checks++;
            if (out_valid !== ev || (ev && {out_sel, out_data} !== {es, ed})) begin
                errors++;
                $display("FAIL single_out c=%0d got v=%b s=%b d=%h exp v=%b s=%b d=%h",
                         c, out_valid, out_sel, out_data, ev, es, ed);
            end
            if (al[c]) begin
                ev = 1'b1; ed = data_lsb; es = 1'b0; cl++;
            end else if (out_ready) begin
                ev = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        bit gl [8];
        bit gm [8];
        int cl, cm;
        gl = '{0, 1, 1, 0, 0, 0, 0, 1};
        gm = '{0, 0, 0, 0, 1, 1, 0, 0};
        cl = 0;
        cm = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req_lsb  = 1'b1;
            data_lsb = NBITS'(8'h10 + cl);
            last_lsb = (cl % 2 == 1);
            req_msb  = 1'b1;
            data_msb = NBITS'(8'h50 + cm);
            last_msb = (cm % 2 == 1);
            #1;
            checks++;
            if ({grant_lsb, grant_msb, busy} !== {gl[c], gm[c], gl[c] | gm[c]}) begin
                errors++;
                $display("FAIL rr_status c=%0d got %b exp %b", c,
                         {grant_lsb, grant_msb, busy}, {gl[c], gm[c], gl[c] | gm[c]});
            end
            checks++;
            if ({ack_lsb, ack_msb} !== {gl[c], gm[c]}) begin
                errors++;
                $display("FAIL rr_ack c=%0d got %b exp %b", c, {ack_lsb, ack_msb}, {gl[c], gm[c]});
            end
            checks++;
            if (out_valid !== ev || (ev && {out_sel, out_data} !== {es, ed})) begin
                errors++;
                $display("FAIL rr_out c=%0d got v=%b s=%b d=%h exp v=%b s=%b d=%h",
                         c, out_valid, out_sel, out_data, ev, es, ed);
            end
            if (gl[c]) begin
                ev = 1'b1; ed = data_lsb; es = 1'b0; cl++;
            end else if (gm[c]) begin
                ev = 1'b1; ed = data_msb; es = 1'b1; cm++;
            end else if (out_ready) begin
                ev = 1'b0;
            end
            step();
        end
        req_lsb = 1'b0;
        req_msb = 1'b0;
    endtask

    task automatic test_max_burst();
        bit gl [2][9];
        bit gm [2][9];
        bit al [2][9];
        bit am [2][9];
        int cl, cm;
        gl = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 1, 0, 0}};
        gm = '{'{0, 1, 1, 1, 1, 0, 1, 1, 1}, '{0, 1, 1, 1, 1, 0, 0, 0, 1}};
        al = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 1, 0, 0}};
        am = '{'{0, 1, 1, 1, 1, 0, 1, 1, 0}, '{0, 1, 1, 1, 1, 0, 0, 0, 1}};
        for (int v = 0; v < 2; v++) begin
            do_reset();
            cl = 0;
            cm = 0;
            for (int c = 0; c < 9; c++) begin
                req_msb  = (cm < 6);
                data_msb = NBITS'(8'h60 + cm);
                last_msb = 1'b0;
                req_lsb  = (v == 1) && (c >= 3) && (cl < 1);
                data_lsb = NBITS'(8'h20);
                last_lsb = 1'b1;
                #1;
                checks++;
                if ({grant_lsb, grant_msb} !== {gl[v][c], gm[v][c]}) begin
                    errors++;
                    $display("FAIL max_grant v=%0d c=%0d got %b exp %b", v, c,
                             {grant_lsb, grant_msb}, {gl[v][c], gm[v][c]});
                end
                checks++;
                if ({ack_lsb, ack_msb} !== {al[v][c], am[v][c]}) begin
                    errors++;
                    $display("FAIL max_ack v=%0d c=%0d got %b exp %b", v, c,
                             {ack_lsb, ack_msb}, {al[v][c], am[v][c]});
                end
                checks++;
                if (out_valid !== ev || (ev && {out_sel, out_data} !== {es, ed})) begin
                    errors++;
                    $display("FAIL max_out v=%0d c=%0d got v=%b s=%b d=%h exp v=%b s=%b d=%h",
                             v, c, out_valid, out_sel, out_data, ev, es, ed);
                end
                if (al[v][c]) begin
                    ev = 1'b1; ed = data_lsb; es = 1'b0; cl++;
                end else if (am[v][c]) begin
                    ev = 1'b1; ed = data_msb; es = 1'b1; cm++;
                end else if (out_ready) begin
                    ev = 1'b0;
                end
                step();
            end
        end
    endtask

    task automatic test_backpressure();
        bit gl [8];
        bit al [8];
        bit rd [8];
        int cl;
        gl = '{0, 1, 1, 1, 1, 1, 1, 0};
        al = '{0, 1, 0, 0, 0, 1, 1, 0};
        rd = '{1, 1, 0, 0, 0, 1, 1, 1};
        cl = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req_lsb   = (cl < 3);
            data_lsb  = NBITS'(8'h40 + cl);
            last_lsb  = (cl == 2);
            out_ready = rd[c];
            #1;
            checks++;
            if ({grant_lsb, busy} !== {gl[c], gl[c]}) begin
                errors++;
                $display("FAIL bp_status c=%0d got %b exp %b", c, {grant_lsb, busy}, {gl[c], gl[c]});
            end
            checks++;
            if ({ack_lsb, ack_msb} !== {al[c], 1'b0}) begin
                errors++;
                $display("FAIL bp_ack c=%0d got %b exp %b", c, {ack_lsb, ack_msb}, {al[c], 1'b0});
            end
            checks++;
            if (out_valid !== ev || (ev && {out_sel, out_data} !== {es, ed})) begin
                errors++;
                $display("FAIL bp_out c=%0d got v=%b s=%b d=%h exp v=%b s=%b d=%h",
                         c, out_valid, out_sel, out_data, ev, es, ed);
            end
            if (al[c]) begin
                ev = 1'b1; ed = data_lsb; es = 1'b0; cl++;
            end else if (ev && out_ready) begin
                ev = 1'b0;
            end
            step();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_req_drop();
        bit rl [8];
        bit gl [8];
        bit gm [8];
        bit al [8];
        bit am [8];
        int cl, cm;
        rl = '{1, 1, 0, 0, 1, 1, 0, 0};
        gl = '{0, 1, 1, 1, 1, 1, 0, 0};
        gm = '{0, 0, 0, 0, 0, 0, 0, 1};
        al = '{0, 1, 0, 0, 1, 1, 0, 0};
        am = '{0, 0, 0, 0, 0, 0, 0, 1};
        cl = 0;
        cm = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req_lsb  = rl[c] && (cl < 3);
            data_lsb = NBITS'(8'h30 + cl);
            last_lsb = (cl == 2);
            req_msb  = (cm < 1);
            data_msb = NBITS'(8'h70);
            last_msb = 1'b1;
            #1;
            checks++;
            if ({grant_lsb, grant_msb, busy} !== {gl[c], gm[c], gl[c] | gm[c]}) begin
                errors++;
                $display("FAIL drop_status c=%0d got %b exp %b", c,
                         {grant_lsb, grant_msb, busy}, {gl[c], gm[c], gl[c] | gm[c]});
            end
            checks++;
            if ({ack_lsb, ack_msb} !== {al[c], am[c]}) begin
                errors++;
                $display("FAIL drop_ack c=%0d got %b exp %b", c, {ack_lsb, ack_msb}, {al[c], am[c]});
            end
            checks++;
            if (out_valid !== ev || (ev && {out_sel, out_data} !== {es, ed})) begin
                errors++;
                $display("FAIL drop_out c=%0d got v=%b s=%b d=%h exp v=%b s=%b d=%h",
                         c, out_valid, out_sel, out_data, ev, es, ed);
            end
            if (al[c]) begin
                ev = 1'b1; ed = data_lsb; es = 1'b0; cl++;
            end else if (am[c]) begin
                ev = 1'b1; ed = data_msb; es = 1'b1; cm++;
            end else if (out_ready) begin
                ev = 1'b0;
            end
            step();
        end
        req_lsb = 1'b0;
        req_msb = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        // One LSB beat moves the pointer to LSB, so a surviving pointer would favour MSB.
        req_lsb  = 1'b1;
        data_lsb = NBITS'(8'h01);
        last_lsb = 1'b1;
        step();
        #1;
        checks++;
        if ({grant_lsb, ack_lsb} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_lsb c=1 got %b exp 11", {grant_lsb, ack_lsb});
        end
        step();
        req_lsb  = 1'b0;
        req_msb  = 1'b1;
        data_msb = NBITS'(8'h55);
        last_msb = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_bubble c=2 got %b exp 0", busy);
        end
        step();
        #1;
        checks++;
        if ({grant_msb, ack_msb} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_msb c=3 got %b exp 11", {grant_msb, ack_msb});
        end
        step();
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 7'h55}) begin
            errors++;
            $display("FAIL rstmid_out c=4 got %h exp %h",
                     {out_valid, out_sel, out_data}, {1'b1, 1'b1, 7'h55});
        end
        rst = 1'b1;
        step();
        rst      = 1'b0;
        req_lsb  = 1'b1;
        req_msb  = 1'b1;
        data_lsb = NBITS'(8'h02);
        last_lsb = 1'b1;
        #1;
        checks++;
        if ({out_data, out_sel, out_valid, grant_lsb, grant_msb, busy, ack_lsb, ack_msb} !== 14'h0) begin
            errors++;
            $display("FAIL rstmid_clear c=5 got %h exp 0",
                     {out_data, out_sel, out_valid, grant_lsb, grant_msb, busy, ack_lsb, ack_msb});
        end
        step();
        #1;
        checks++;
        if ({grant_lsb, grant_msb} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_tie c=6 got %b exp 10", {grant_lsb, grant_msb});
        end
        req_lsb = 1'b0;
        req_msb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_lsb();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_req_drop();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
